// File: rtl/byte_serial_add_seq_pkg.sv
// add_seq_pkg: shared state type, byte width and sizing helpers for the byte-serial adder
package add_seq_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int num_bytes(input int width);
    return width / BYTE_W;
  endfunction
  function automatic int idx_width(input int width);
    return (width / BYTE_W > 1) ? $clog2(width / BYTE_W) : 1;
  endfunction
endpackage

// File: rtl/byte_serial_add_seq_if.sv
// byte_serial_add_seq_if: requester <-> sequencer bundle; op_sub exists only with ADDSEQ_SUB_EN
interface byte_serial_add_seq_if #(parameter int WIDTH = 32);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef ADDSEQ_SUB_EN
  logic             op_sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef ADDSEQ_SUB_EN
  modport master (output start, a, b, op_sub, input busy, done, sum, cout);
  modport slave  (input start, a, b, op_sub, output busy, done, sum, cout);
`else
  modport master (output start, a, b, input busy, done, sum, cout);
  modport slave  (input start, a, b, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/byte_serial_add_seq_slice.sv
// byte_add_slice: combinational 8-bit adder with carry in/out, the single shared datapath
import add_seq_pkg::*;
module byte_add_slice (
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] s,
  output logic              cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, cin};
endmodule

// File: rtl/byte_serial_add_seq.sv
// byte_serial_add_seq: WIDTH-bit add via one 8-bit slice, LSB byte first, carry chained in a register.
// Define ADDSEQ_SUB_EN to add the op_sub input (a - b via ~b and carry-in 1).
import add_seq_pkg::*;
module byte_serial_add_seq #(parameter int WIDTH = 32) (
  input logic clk,
  input logic rst,
  byte_serial_add_seq_if.slave bus
);
  localparam int N  = num_bytes(WIDTH);
  localparam int IW = idx_width(WIDTH);
  state_t           state, nxt;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry, cout_q, accept, last, slice_co, cin0;
  logic [WIDTH-1:0] b_in;
  logic [BYTE_W-1:0] a_byte, b_byte, slice_s;
`ifdef ADDSEQ_SUB_EN
  // Subtraction folds into the latched operand: a + ~b + 1
  assign b_in = bus.op_sub ? ~bus.b : bus.b;
  assign cin0 = bus.op_sub;
`else
  assign b_in = bus.b;
  assign cin0 = 1'b0;
`endif
  assign accept = bus.start && (state == IDLE || state == DONE);
  assign last   = idx == IW'(N - 1);
  assign a_byte = a_q[int'(idx)*BYTE_W +: BYTE_W];
  assign b_byte = b_q[int'(idx)*BYTE_W +: BYTE_W];
  byte_add_slice u_slice (
    .a    (a_byte),
    .b    (b_byte),
    .cin  (carry),
    .s    (slice_s),
    .cout (slice_co)
  );
  always_comb begin
    nxt = accept ? RUN : (state == RUN) ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      carry  <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
    end else if (accept) begin
      a_q   <= bus.a;
      b_q   <= b_in;
      idx   <= '0;
      carry <= cin0;
      sum_q <= '0;
    end else if (state == RUN) begin
      sum_q[int'(idx)*BYTE_W +: BYTE_W] <= slice_s;
      carry <= slice_co;
      if (last) cout_q <= slice_co;
      else      idx <= idx + 1'b1;
    end
  end
  assign bus.busy = state == RUN;
  assign bus.done = state == DONE;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_byte_serial_add_seq.sv
// tb_byte_serial_add_seq: directed vectors with hand-computed results for byte_serial_add_seq
module tb_byte_serial_add_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int cnt;
  byte_serial_add_seq_if #(.WIDTH(32)) bus ();
  byte_serial_add_seq #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic sub);
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
`ifdef ADDSEQ_SUB_EN
    bus.op_sub = sub;
`else
    if (sub) $display("note: subtraction requested in add-only build");
`endif
  endtask
  task automatic wait_done(input string tag);
    cnt = 0;
    while (!bus.done && cnt < 12) begin
      tick();
      cnt++;
    end
    check({tag, "_lat"}, 64'(cnt), 64'd4);
  endtask
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic [31:0] exp_sum, input logic exp_cout);
    drive(a, b, sub);
    tick();
    bus.start = 1'b0;
    bus.a = '1;
    bus.b = '1;
    check({tag, "_busy"}, 64'(bus.busy), 64'd1);
    wait_done(tag);
    check({tag, "_sum"}, 64'(bus.sum), 64'(exp_sum));
    check({tag, "_cout"}, 64'(bus.cout), 64'(exp_cout));
    check({tag, "_nobusy"}, 64'(bus.busy), 64'd0);
  endtask
  initial begin
    drive(32'h1, 32'h2, 1'b0);
    tick();
    tick();
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_sum", 64'(bus.sum), 64'd0);
    check("rst_cout", 64'(bus.cout), 64'd0);
    rst = 1'b0;
    bus.start = 1'b0;
    tick();
    check("idle_busy", 64'(bus.busy), 64'd0);
    run_op("ripple", 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0);
    tick();
    check("done_fall", 64'(bus.done), 64'd0);
    run_op("wrap", 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1);
    tick();
    run_op("mixed", 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0);
    tick();
    drive(32'h10, 32'h20, 1'b0);
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("ign_busy", 64'(bus.busy), 64'd1);
      check("ign_done", 64'(bus.done), 64'd0);
      if (i == 1) drive(32'h1, 32'h1, 1'b0);
      tick();
      bus.start = 1'b0;
    end
    check("ign_donehi", 64'(bus.done), 64'd1);
    check("ign_sum", 64'(bus.sum), 64'h30);
    tick();
    check("ign_single", 64'(bus.done), 64'd0);
    run_op("b2b1", 32'h1, 32'h2, 1'b0, 32'h3, 1'b0);
    drive(32'h100, 32'h200, 1'b0);
    tick();
    bus.start = 1'b0;
    check("b2b_busy", 64'(bus.busy), 64'd1);
    check("b2b_done", 64'(bus.done), 64'd0);
    wait_done("b2b2");
    check("b2b2_sum", 64'(bus.sum), 64'h300);
    tick();
    drive(32'h5, 32'h6, 1'b0);
    tick();
    bus.start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_sum", 64'(bus.sum), 64'd0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.done) cnt++;
    end
    check("abort_nodone", 64'(cnt), 64'd0);
`ifdef ADDSEQ_SUB_EN
    run_op("sub_neg", 32'h5, 32'h7, 1'b1, 32'hFFFFFFFE, 1'b0);
    tick();
    run_op("sub_pos", 32'h7, 32'h5, 1'b1, 32'h00000002, 1'b1);
    tick();
    run_op("add_after_sub", 32'h7, 32'h5, 1'b0, 32'h0000000C, 1'b0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
